sdram_refresh_engine: RTL and testbench

Consumer side of the refresh-pending/clear handshake. The refresh-interval counter raises refresh_pending. This engine then:
- requests the command bus from the main controller FSM;
- on grant, issues PRECHARGE ALL (if needed) and REF_BURST AUTO REFRESH commands with tRP/tRFC spacing;
- pulses refresh_clear_pulse to re-arm the counter.
Sits between the refresh counter and the SDRAM command mux.

---
 rtl/sdram_refresh_engine_pkg.sv | 29 ++
 rtl/sdram_refresh_engine_if.sv | 25 ++
 rtl/sdram_refresh_engine.sv | 174 +++++++++++++++++
 tb/tb_sdram_refresh_engine.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_refresh_engine_pkg.sv
// Shared SDRAM definitions for the refresh engine: command encodings,
// refresh FSM state type and default timing constants.
package sdram_pkg;

   // {cs_n, ras_n, cas_n, we_n}
   localparam logic [3:0] CMD_NOP       = 4'b0111;
   localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
   localparam logic [3:0] CMD_REFRESH   = 4'b0001;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_PRE,
      ST_WAIT_RP,
      ST_REF,
      ST_WAIT_RFC,
      ST_DONE
   } ref_state_t;

   localparam int DEF_T_RP      = 3;
   localparam int DEF_T_RFC     = 9;
   localparam int DEF_REF_BURST = 1;
   localparam int DEF_T_URGENT  = 1000;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sdram_refresh_engine_if.sv
// Command-bus handshake between the refresh engine (master) and the
// main controller FSM / command mux (slave).
interface sdram_refresh_engine_if;
   logic       ref_req;
   logic       ref_gnt;
   logic [3:0] cmd;
   logic       a10;
   logic       ref_urgent;

   modport master (
      output ref_req,
      output cmd,
      output a10,
      output ref_urgent,
      input  ref_gnt
   );

   modport slave (
      input  ref_req,
      input  cmd,
      input  a10,
      input  ref_urgent,
      output ref_gnt
   );
endinterface

// File: rtl/sdram_refresh_engine.sv
// Refresh engine: on refresh_pending, wins the command bus, issues PRECHARGE ALL
// (when banks are open) and a burst of AUTO REFRESH, then re-arms the counter.
// Optional grant-starvation flag enabled by defining SDRAM_REF_URGENT_EN.
module sdram_refresh_engine
   import sdram_pkg::*;
#(
   parameter int T_RP      = DEF_T_RP,
   parameter int T_RFC     = DEF_T_RFC,
   parameter int REF_BURST = DEF_REF_BURST
`ifdef SDRAM_REF_URGENT_EN
   ,
   parameter int T_URGENT  = DEF_T_URGENT
`endif
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_init,
   input  logic                          refresh_pending,
   input  logic                          all_banks_idle,
   sdram_refresh_engine_if.master        bus,
   output logic                          refresh_clear_pulse,
   output logic                          ref_busy
);

   localparam int WAIT_W = $clog2(max_int(T_RP, T_RFC)) + 1;

   // Wait states last (T - 1) cycles, so the counter exits at T - 2.
   localparam logic [WAIT_W-1:0] RP_LAST  = WAIT_W'((T_RP  >= 2) ? T_RP  - 2 : 0);
   localparam logic [WAIT_W-1:0] RFC_LAST = WAIT_W'((T_RFC >= 2) ? T_RFC - 2 : 0);
   localparam logic [3:0]        BURST_N  = 4'(REF_BURST);

   ref_state_t        state_reg, state_next;
   logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
   logic [3:0]        burst_cnt_reg, burst_cnt_next;
   logic [3:0]        cmd_reg, cmd_next;
   logic              a10_reg, a10_next;
   logic              req_reg, req_next;
   logic              clear_reg, clear_next;
   logic              busy_reg, busy_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         wait_cnt_reg  <= '0;
         burst_cnt_reg <= '0;
         cmd_reg       <= CMD_NOP;
         a10_reg       <= 1'b0;
         req_reg       <= 1'b0;
         clear_reg     <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         wait_cnt_reg  <= wait_cnt_next;
         burst_cnt_reg <= burst_cnt_next;
         cmd_reg       <= cmd_next;
         a10_reg       <= a10_next;
         req_reg       <= req_next;
         clear_reg     <= clear_next;
         busy_reg      <= busy_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (refresh_pending && !in_init)
               state_next = ST_REQ;
         end
         ST_REQ: begin
            if (in_init || !refresh_pending)
               state_next = ST_IDLE;
            else if (bus.ref_gnt)
               state_next = all_banks_idle ? ST_REF : ST_PRE;
         end
         ST_PRE: begin
            state_next = (T_RP == 1) ? ST_REF : ST_WAIT_RP;
         end
         ST_WAIT_RP: begin
            if (wait_cnt_reg == RP_LAST)
               state_next = ST_REF;
         end
         ST_REF: begin
            // burst_cnt_reg still holds the count before this REF
            if (T_RFC == 1)
               state_next = ((burst_cnt_reg + 4'd1) < BURST_N) ? ST_REF : ST_DONE;
            else
               state_next = ST_WAIT_RFC;
         end
         ST_WAIT_RFC: begin
            if (wait_cnt_reg == RFC_LAST)
               state_next = (burst_cnt_reg < BURST_N) ? ST_REF : ST_DONE;
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      wait_cnt_next = '0;
      if ((state_next == state_reg) &&
          ((state_reg == ST_WAIT_RP) || (state_reg == ST_WAIT_RFC)))
         wait_cnt_next = wait_cnt_reg + 1'b1;

      burst_cnt_next = burst_cnt_reg;
      if (state_reg == ST_IDLE)
         burst_cnt_next = '0;
      else if (state_reg == ST_REF)
         burst_cnt_next = burst_cnt_reg + 4'd1;
   end

   // Outputs are decoded from the next state and registered, so they line up
   // with state_reg without any combinational path to the pins.
   always_comb begin
      cmd_next   = CMD_NOP;
      a10_next   = 1'b0;
      req_next   = 1'b0;
      clear_next = 1'b0;
      busy_next  = 1'b0;
      if (state_next == ST_PRE) begin
         cmd_next = CMD_PRECHARGE;
         a10_next = 1'b1;
      end
      if (state_next == ST_REF)
         cmd_next = CMD_REFRESH;
      if (state_next == ST_DONE)
         clear_next = 1'b1;
      if (state_next != ST_IDLE) begin
         req_next  = 1'b1;
         busy_next = 1'b1;
      end
   end

   assign bus.cmd             = cmd_reg;
   assign bus.a10             = a10_reg;
   assign bus.ref_req         = req_reg;
   assign refresh_clear_pulse = clear_reg;
   assign ref_busy            = busy_reg;

`ifdef SDRAM_REF_URGENT_EN
   localparam int              URG_W   = $clog2(max_int(T_URGENT, 1) + 1) + 1;
   localparam logic [URG_W-1:0] URG_MAX = URG_W'(T_URGENT);

   logic [URG_W-1:0] urg_cnt_reg, urg_cnt_next;
   logic             urgent_reg, urgent_next;

   // Counts completed REQ cycles, saturating at the threshold.
   always_comb begin
      urg_cnt_next = '0;
      if ((state_reg == ST_REQ) && (state_next == ST_REQ))
         urg_cnt_next = (urg_cnt_reg >= URG_MAX) ? urg_cnt_reg : urg_cnt_reg + 1'b1;
      urgent_next = (state_next == ST_REQ) && (urg_cnt_next >= URG_MAX);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         urg_cnt_reg <= '0;
         urgent_reg  <= 1'b0;
      end else begin
         urg_cnt_reg <= urg_cnt_next;
         urgent_reg  <= urgent_next;
      end
   end

   assign bus.ref_urgent = urgent_reg;
`else
   assign bus.ref_urgent = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_refresh_engine.sv
// Scoreboard bench for sdram_refresh_engine: two instances (single refresh and
// a burst of four); stimulus queues expected commands, monitors compare them.
module tb_sdram_refresh_engine;
   import sdram_pkg::*;

   localparam bit URG_EN =
`ifdef SDRAM_REF_URGENT_EN
      1'b1;
`else
      1'b0;
`endif

   typedef struct {
      int         cyc;
      logic [3:0] cmd;
      logic       a10;
      logic       clr;
   } ev_t;

   logic clk = 1'b0;
   logic rst_a, init_a, pend_a, idle_a, clr_a, busy_a;
   logic rst_b, init_b, pend_b, idle_b, clr_b, busy_b;
   int   cyc = 0;
   int   chk_n = 0;
   int   err_n = 0;
   ev_t  qa[$];
   ev_t  qb[$];

   sdram_refresh_engine_if ifa ();
   sdram_refresh_engine_if ifb ();

   sdram_refresh_engine #(
      .T_RP(3), .T_RFC(9), .REF_BURST(1)
`ifdef SDRAM_REF_URGENT_EN
      , .T_URGENT(20)
`endif
   ) u_a (
      .clk(clk), .rst(rst_a), .in_init(init_a), .refresh_pending(pend_a),
      .all_banks_idle(idle_a), .bus(ifa), .refresh_clear_pulse(clr_a), .ref_busy(busy_a)
   );

   sdram_refresh_engine #(
      .T_RP(3), .T_RFC(9), .REF_BURST(4)
`ifdef SDRAM_REF_URGENT_EN
      , .T_URGENT(20)
`endif
   ) u_b (
      .clk(clk), .rst(rst_b), .in_init(init_b), .refresh_pending(pend_b),
      .all_banks_idle(idle_b), .bus(ifb), .refresh_clear_pulse(clr_b), .ref_busy(busy_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_n++;
      if (act !== exp) begin
         err_n++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_ev(input string name, input ev_t act, input ev_t exp);
      chk_n++;
      if (act.cyc != exp.cyc || act.cmd !== exp.cmd || act.a10 !== exp.a10 || act.clr !== exp.clr) begin
         err_n++;
         $display("FAIL %s: got cyc=%0d cmd=%b a10=%b clr=%b, expected cyc=%0d cmd=%b a10=%b clr=%b",
                  name, act.cyc, act.cmd, act.a10, act.clr, exp.cyc, exp.cmd, exp.a10, exp.clr);
      end
   endtask

   task automatic goto(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   always @(negedge clk) begin : mon_a
      ev_t act_e;
      if (ifa.cmd !== CMD_NOP || ifa.a10 !== 1'b0 || clr_a !== 1'b0) begin
         act_e = '{cyc, ifa.cmd, ifa.a10, clr_a};
         $display("A cyc=%0d cmd=%b a10=%b clr=%b", cyc, ifa.cmd, ifa.a10, clr_a);
         if (qa.size() == 0) begin
            chk_n++;
            err_n++;
            $display("FAIL mon_a_unexpected: got cmd=%b a10=%b clr=%b at cycle %0d, expected no event",
                     ifa.cmd, ifa.a10, clr_a, cyc);
         end else begin
            check_ev("mon_a", act_e, qa.pop_front());
         end
      end
   end

   always @(negedge clk) begin : mon_b
      ev_t act_e;
      if (ifb.cmd !== CMD_NOP || ifb.a10 !== 1'b0 || clr_b !== 1'b0) begin
         act_e = '{cyc, ifb.cmd, ifb.a10, clr_b};
         $display("B cyc=%0d cmd=%b a10=%b clr=%b", cyc, ifb.cmd, ifb.a10, clr_b);
         if (qb.size() == 0) begin
            chk_n++;
            err_n++;
            $display("FAIL mon_b_unexpected: got cmd=%b a10=%b clr=%b at cycle %0d, expected no event",
                     ifb.cmd, ifb.a10, clr_b, cyc);
         end else begin
            check_ev("mon_b", act_e, qb.pop_front());
         end
      end
   end

   initial begin
      int c0;
      int p;
      int g;
      rst_a = 1'b1; init_a = 1'b0; pend_a = 1'b0; idle_a = 1'b0; ifa.ref_gnt = 1'b0;
      rst_b = 1'b1; init_b = 1'b0; pend_b = 1'b0; idle_b = 1'b0; ifb.ref_gnt = 1'b0;
      repeat (3) @(negedge clk);
      rst_a = 1'b0;
      rst_b = 1'b0;
      @(negedge clk);

      // Reset state
      check("rst_cmd",    32'(ifa.cmd), 32'(CMD_NOP));
      check("rst_a10",    32'(ifa.a10), 32'd0);
      check("rst_req",    32'(ifa.ref_req), 32'd0);
      check("rst_clr",    32'(clr_a), 32'd0);
      check("rst_busy",   32'(busy_a), 32'd0);
      check("rst_urgent", 32'(ifa.ref_urgent), 32'd0);
      check("rst_b_busy", 32'(busy_b), 32'd0);

      // Banks open, immediate grant: PRE at 2, REF at 5, DONE at 14
      ifa.ref_gnt = 1'b1;
      idle_a = 1'b0;
      c0 = cyc;
      qa.push_back('{c0 + 2,  CMD_PRECHARGE, 1'b1, 1'b0});
      qa.push_back('{c0 + 5,  CMD_REFRESH,   1'b0, 1'b0});
      qa.push_back('{c0 + 14, CMD_NOP,       1'b0, 1'b1});
      pend_a = 1'b1;
      goto(c0 + 1);
      check("t1_req",  32'(ifa.ref_req), 32'd1);
      check("t1_busy", 32'(busy_a), 32'd1);
      goto(c0 + 14);
      pend_a = 1'b0;
      goto(c0 + 15);
      check("t1_idle_busy", 32'(busy_a), 32'd0);
      check("t1_idle_req",  32'(ifa.ref_req), 32'd0);
      goto(c0 + 17);
      check("t1_no_rerun", 32'(busy_a), 32'd0);

      // in_init holds the engine idle; banks idle skips PRECHARGE; in_init mid-sequence ignored
      init_a = 1'b1;
      idle_a = 1'b1;
      p = cyc;
      pend_a = 1'b1;
      goto(p + 3);
      check("t2_init_hold", 32'(ifa.ref_req), 32'd0);
      c0 = p + 4;
      qa.push_back('{c0 + 2,  CMD_REFRESH, 1'b0, 1'b0});
      qa.push_back('{c0 + 11, CMD_NOP,     1'b0, 1'b1});
      goto(c0);
      init_a = 1'b0;
      goto(c0 + 3);
      init_a = 1'b1;
      goto(c0 + 11);
      pend_a = 1'b0;
      goto(c0 + 12);
      check("t2_done_busy", 32'(busy_a), 32'd0);
      init_a = 1'b0;
      idle_a = 1'b0;

      // Grant withheld 50 cycles; grant dropped after start is ignored
      ifa.ref_gnt = 1'b0;
      c0 = cyc;
      g = c0 + 51;
      qa.push_back('{g + 1,  CMD_PRECHARGE, 1'b1, 1'b0});
      qa.push_back('{g + 4,  CMD_REFRESH,   1'b0, 1'b0});
      qa.push_back('{g + 13, CMD_NOP,       1'b0, 1'b1});
      pend_a = 1'b1;
      for (int k = 1; k <= 51; k++) begin
         goto(c0 + k);
         check("t4_req_held", 32'(ifa.ref_req), 32'd1);
         check("t4_urgent", 32'(ifa.ref_urgent), 32'(URG_EN && (k >= 21)));
      end
      ifa.ref_gnt = 1'b1;
      goto(g + 1);
      ifa.ref_gnt = 1'b0;
      check("t4_urgent_fall", 32'(ifa.ref_urgent), 32'd0);
      goto(g + 13);
      pend_a = 1'b0;
      goto(g + 14);
      check("t4_done_busy", 32'(busy_a), 32'd0);

      // Reset during WAIT_RFC aborts the sequence, no clear pulse
      ifa.ref_gnt = 1'b1;
      c0 = cyc;
      qa.push_back('{c0 + 2, CMD_PRECHARGE, 1'b1, 1'b0});
      qa.push_back('{c0 + 5, CMD_REFRESH,   1'b0, 1'b0});
      pend_a = 1'b1;
      goto(c0 + 7);
      check("t5_in_wait", 32'(busy_a), 32'd1);
      rst_a = 1'b1;
      pend_a = 1'b0;
      goto(c0 + 8);
      rst_a = 1'b0;
      check("t5_busy", 32'(busy_a), 32'd0);
      check("t5_req",  32'(ifa.ref_req), 32'd0);
      check("t5_cmd",  32'(ifa.cmd), 32'(CMD_NOP));
      check("t5_clr",  32'(clr_a), 32'd0);
      goto(c0 + 20);
      check("t5_stay_idle", 32'(busy_a), 32'd0);

      // Burst of four: REF every 9 cycles, single clear pulse
      ifb.ref_gnt = 1'b1;
      c0 = cyc;
      qb.push_back('{c0 + 2,  CMD_PRECHARGE, 1'b1, 1'b0});
      qb.push_back('{c0 + 5,  CMD_REFRESH,   1'b0, 1'b0});
      qb.push_back('{c0 + 14, CMD_REFRESH,   1'b0, 1'b0});
      qb.push_back('{c0 + 23, CMD_REFRESH,   1'b0, 1'b0});
      qb.push_back('{c0 + 32, CMD_REFRESH,   1'b0, 1'b0});
      qb.push_back('{c0 + 41, CMD_NOP,       1'b0, 1'b1});
      pend_b = 1'b1;
      goto(c0 + 41);
      pend_b = 1'b0;
      goto(c0 + 43);
      check("t3_done_busy", 32'(busy_b), 32'd0);

      check("qa_drained", 32'(qa.size()), 32'd0);
      check("qb_drained", 32'(qb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", chk_n, err_n);
      $finish;
   end

endmodule
